// File: rtl/bdc_pkg.sv
// Types and defaults shared between the video input bridge and the barrel distortion correction stage.
package bdc_pkg;
    localparam int DATA_WIDTH_DEF = 24;
    localparam int WIDTH_DEF      = 1920;
    localparam int HEIGHT_DEF     = 1080;
    localparam int DROP_CNT_W     = 16;

    // FIFO entry is {tuser, tlast, data}; these are bit offsets above the data field.
    localparam int TLAST_BIT = 0;
    localparam int TUSER_BIT = 1;

    typedef enum logic [1:0] {
        ST_WAIT_VSYNC,
        ST_ARMED,
        ST_ACTIVE,
        ST_DROP
    } vin_state_e;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of two.
module axis_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rd_data = r_mem[r_rptr];

    // A push while full is accepted only when the head leaves in the same cycle.
    assign w_pop  = i_rd_en & ~o_empty;
    assign w_push = i_wr_en & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/video_in_to_axis.sv
// Parallel pixel bus (data/DE/vsync) to AXI4-Stream video with overflow drop and re-lock on vsync.
// Optional frame size measurement when VID_IN_MEASURE_EN is defined.
module video_in_to_axis
    import bdc_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int HEIGHT     = HEIGHT_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = 64,
    parameter bit VSYNC_POL  = 1'b1
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         vid_data,
    input  logic                          vid_de,
    input  logic                          vid_vsync,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    input  logic                          m_axis_tready,
    input  logic                          ovf_clr,
    output logic                          overflow,
    output logic [DROP_CNT_W-1:0]         drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   meas_width,
    output logic [15:0]                   meas_height,
    output logic                          meas_valid
);
    localparam int          EW     = DATA_WIDTH + 2;
    localparam logic [15:0] X_LAST = 16'(WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_de;
    logic                  r_vs;
    logic                  r_vs_d;
    logic                  w_vs_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_de   <= 1'b0;
            r_vs   <= 1'b0;
            r_vs_d <= 1'b0;
        end else begin
            r_data <= vid_data;
            r_de   <= vid_de;
            r_vs   <= VSYNC_POL ? vid_vsync : ~vid_vsync;
            r_vs_d <= r_vs;
        end
    end

    assign w_vs_edge = r_vs & ~r_vs_d;

    vin_state_e            r_state;
    logic [15:0]           r_x;
    logic [15:0]           r_y;
    logic                  r_wr;
    logic [EW-1:0]         r_wr_entry;
    logic                  r_ovf;
    logic [DROP_CNT_W-1:0] r_drop;

    logic                  w_full;
    logic                  w_empty;
    logic [EW-1:0]         w_rd_entry;
    logic                  w_rd;
    logic                  w_wr_lost;
    logic                  w_line_end;
    logic                  w_frame_end;

    assign w_rd        = m_axis_tvalid & m_axis_tready;
    assign w_wr_lost   = r_wr & w_full & ~w_rd;
    assign w_line_end  = (r_x == X_LAST);
    assign w_frame_end = w_line_end & (r_y == Y_LAST);

    // The write request is registered here and lands in the FIFO one edge later,
    // so overflow is judged against the FIFO state at the moment of that write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_WAIT_VSYNC;
            r_x        <= '0;
            r_y        <= '0;
            r_wr       <= 1'b0;
            r_wr_entry <= '0;
            r_ovf      <= 1'b0;
            r_drop     <= '0;
        end else begin
            r_wr <= 1'b0;
            if (ovf_clr)   r_ovf <= 1'b0;
            if (w_wr_lost) r_ovf <= 1'b1;

            if (w_vs_edge) begin
                r_state <= ST_ARMED;
                r_x     <= '0;
                r_y     <= '0;
                // A frame lost to overflow and cut short at the same time counts once.
                if (w_wr_lost || r_state == ST_ACTIVE) r_drop <= sat_inc(r_drop);
            end else if (w_wr_lost) begin
                r_state <= ST_DROP;
                r_drop  <= sat_inc(r_drop);
            end else begin
                case (r_state)
                    ST_ARMED, ST_ACTIVE: begin
                        if (r_de) begin
                            r_wr       <= 1'b1;
                            r_wr_entry <= {(r_state == ST_ARMED), w_line_end, r_data};
                            r_state    <= w_frame_end ? ST_WAIT_VSYNC : ST_ACTIVE;
                            if (w_line_end) begin
                                r_x <= '0;
                                r_y <= r_y + 1'b1;
                            end else begin
                                r_x <= r_x + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    axis_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (r_wr),
        .i_wr_data (r_wr_entry),
        .i_rd_en   (w_rd),
        .o_rd_data (w_rd_entry),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (fifo_level)
    );

    assign m_axis_tvalid = ~w_empty;
    assign m_axis_tdata  = w_empty ? '0 : w_rd_entry[DATA_WIDTH-1:0];
    assign m_axis_tlast  = ~w_empty & w_rd_entry[DATA_WIDTH + TLAST_BIT];
    assign m_axis_tuser  = ~w_empty & w_rd_entry[DATA_WIDTH + TUSER_BIT];
    assign overflow      = r_ovf;
    assign drop_cnt      = r_drop;

`ifdef VID_IN_MEASURE_EN
    logic        r_de_d;
    logic [15:0] r_mw_cnt;
    logic [15:0] r_mh_cnt;
    logic [15:0] r_mw;
    logic [15:0] r_mh;
    logic        r_first_done;
    logic        r_seen_vs;
    logic        r_mv;

    // Measurement follows the raw input timing, independent of the capture FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de_d       <= 1'b0;
            r_mw_cnt     <= '0;
            r_mh_cnt     <= '0;
            r_mw         <= '0;
            r_mh         <= '0;
            r_first_done <= 1'b0;
            r_seen_vs    <= 1'b0;
            r_mv         <= 1'b0;
        end else begin
            r_de_d <= r_de;
            if (w_vs_edge) begin
                if (r_seen_vs) begin
                    r_mw <= r_mw_cnt;
                    r_mh <= r_mh_cnt;
                    r_mv <= 1'b1;
                end
                r_seen_vs    <= 1'b1;
                r_mw_cnt     <= '0;
                r_mh_cnt     <= '0;
                r_first_done <= 1'b0;
            end else begin
                if (r_de && !r_first_done) r_mw_cnt <= r_mw_cnt + 1'b1;
                if (r_de_d && !r_de) begin
                    r_mh_cnt     <= r_mh_cnt + 1'b1;
                    r_first_done <= 1'b1;
                end
            end
        end
    end

    assign meas_width  = r_mw;
    assign meas_height = r_mh;
    assign meas_valid  = r_mv;
`else
    assign meas_width  = '0;
    assign meas_height = '0;
    assign meas_valid  = 1'b0;
`endif
endmodule

// File: tb/tb_video_in_to_axis.sv
// Scoreboard bench for video_in_to_axis: stimulus pushes expected beats, a monitor pops and compares.
module tb_video_in_to_axis;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int DW = 24;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] vid_data = '0;
    logic          vid_de = 1'b0;
    logic          vid_vsync = 1'b0;
    logic          m_axis_tready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic [2:0]    fifo_level;
    logic [15:0]   meas_width;
    logic [15:0]   meas_height;
    logic          meas_valid;

    always #5 clk = ~clk;

    video_in_to_axis #(
        .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .VSYNC_POL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vid_data(vid_data), .vid_de(vid_de), .vid_vsync(vid_vsync),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tready(m_axis_tready), .ovf_clr(ovf_clr),
        .overflow(overflow), .drop_cnt(drop_cnt), .fifo_level(fifo_level),
        .meas_width(meas_width), .meas_height(meas_height), .meas_valid(meas_valid)
    );

    int total = 0;
    int bad   = 0;
    logic [DW+1:0] q[$];
    bit rnd = 1'b0;
    bit ph  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        if (rnd) begin
            ph = ~ph;
            m_axis_tready = ph ? 1'b1 : 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic vsync();
        vid_vsync = 1'b1;
        idle(2);
        vid_vsync = 1'b0;
        idle(2);
    endtask

    // Drives npix pixels; the first npush are expected at the output.
    task automatic frame(input logic [DW-1:0] base, input int npix, input int npush, input int gap);
        logic [DW-1:0] d;
        for (int i = 0; i < npix; i++) begin
            d = base + DW'(i);
            if (i < npush) q.push_back({(i == 0), (i % W == W - 1), d});
            vid_de   = 1'b1;
            vid_data = d;
            tick();
            vid_de   = 1'b0;
            if (gap > 0 && i % 2 == 1) idle(gap);
            if (i % W == W - 1) idle(2);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tvalid"}, m_axis_tvalid, 0);
        chk({tag, "_tdata"},  m_axis_tdata,  0);
        chk({tag, "_tlast"},  m_axis_tlast,  0);
        chk({tag, "_tuser"},  m_axis_tuser,  0);
        chk({tag, "_ovf"},    overflow,      0);
        chk({tag, "_drop"},   drop_cnt,      0);
        chk({tag, "_level"},  fifo_level,    0);
    endtask

    // Monitor: pops on every accepted beat and checks stability during stalls.
    initial begin
        logic          pv = 1'b0;
        logic [DW+1:0] pbeat = '0;
        logic [DW+1:0] act;
        logic [DW+1:0] exp;
        forever begin
            @(negedge clk);
            act = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
            if (pv && rst_n) begin
                chk("stall_valid", m_axis_tvalid, 1);
                chk("stall_beat", act, pbeat);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h expected none", act);
                end else begin
                    exp = q.pop_front();
                    chk("beat", act, exp);
                end
            end
            pv    = rst_n && m_axis_tvalid && !m_axis_tready;
            pbeat = act;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset_mvalid", meas_valid, 0);
        rst_n = 1'b1;
        idle(2);

        // Contiguous frame with first-beat latency check
        m_axis_tready = 1'b1;
        vsync();
        fork
            begin
                @(posedge clk);
                @(posedge clk);
                #1 chk("lat_n1", m_axis_tvalid, 0);
                @(posedge clk);
                #1 chk("lat_n2", m_axis_tvalid, 1);
            end
        join_none
        frame(24'h100000, 32, 32, 0);
        idle(6);

        // DE gaps of 3 cycles every 2 pixels
        vsync();
`ifdef VID_IN_MEASURE_EN
        chk("meas_width", meas_width, 8);
        chk("meas_height", meas_height, 4);
        chk("meas_valid", meas_valid, 1);
`else
        chk("meas_width", meas_width, 0);
        chk("meas_height", meas_height, 0);
        chk("meas_valid", meas_valid, 0);
`endif
        frame(24'h200000, 32, 32, 3);
        idle(6);

        // Overflow: tready low, only the first FD pixels survive
        chk("pre_ovf_level", fifo_level, 0);
        m_axis_tready = 1'b0;
        vsync();
        frame(24'h300000, 32, FD, 0);
        idle(2);
        chk("ovf_set", overflow, 1);
        chk("ovf_drop", drop_cnt, 1);
        chk("ovf_level", fifo_level, FD);
        m_axis_tready = 1'b1;
        idle(8);
        chk("ovf_drained", fifo_level, 0);
        chk("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 0);
        vsync();
        frame(24'h400000, 32, 32, 0);
        idle(6);
        chk("relock_drop", drop_cnt, 1);

        // Short frame: vsync after 2 of 4 lines
        vsync();
        frame(24'h500000, 16, 16, 0);
        vsync();
        chk("short_drop", drop_cnt, 2);
        frame(24'h600000, 32, 32, 0);
        idle(6);

        // Random back-pressure over 3 frames
        rnd = 1'b1;
        for (int f = 0; f < 3; f++) begin
            vsync();
            frame(24'h700000 + DW'(f * 24'h010000), 32, 32, 3);
            idle(10);
        end
        rnd = 1'b0;
        m_axis_tready = 1'b1;
        idle(10);
        chk("rnd_drained", q.size(), 0);

        // Reset mid-frame
        m_axis_tready = 1'b0;
        vsync();
        frame(24'h900000, 3, 0, 0);
        idle(2);
        chk("prerst_valid", m_axis_tvalid, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        idle(2);
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        frame(24'hA00000, 32, 0, 0);
        idle(4);
        chk("novs_valid", m_axis_tvalid, 0);
        chk("novs_level", fifo_level, 0);
        vsync();
        frame(24'hB00000, 32, 32, 0);

        for (int i = 0; i < 200 && q.size() != 0; i++) tick();
        chk("final_drain", q.size(), 0);
        chk("final_drop", drop_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/video_in_to_axis.md
# video_in_to_axis

Converts a parallel pixel bus (data, data-enable, vertical sync) into the AXI4-Stream video format consumed by the barrel distortion correction stage: `tuser` on the first pixel of each frame, `tlast` on the last pixel of each line. Sits directly upstream of that stage. A FIFO absorbs downstream back-pressure. On overflow, the rest of the current frame is dropped and the block re-locks on the next vsync.

## Interface
Parameters:
- `WIDTH`, 1920: active pixels per line.
- `HEIGHT`, 1080: active lines per frame.
- `DATA_WIDTH`, 24: pixel width (RGB888).
- `FIFO_DEPTH`, 64: FIFO entries; power of two, ≥4.
- `VSYNC_POL`, 1: 1 = vsync active-high, 0 = active-low.

Ports:
- `clk`, in, 1: single clock for video input and AXI output.
- `rst_n`, in, 1: asynchronous active-low reset.
- `vid_data`, in, DATA_WIDTH: pixel.
- `vid_de`, in, 1: pixel valid this cycle.
- `vid_vsync`, in, 1: frame sync.
- `m_axis_tdata`, out, DATA_WIDTH: pixel.
- `m_axis_tvalid`, out, 1: beat valid.
- `m_axis_tlast`, out, 1: last pixel of line.
- `m_axis_tuser`, out, 1: first pixel of frame.
- `m_axis_tready`, in, 1: downstream ready.
- `ovf_clr`, in, 1: single-cycle pulse that clears `overflow`.
- `overflow`, out, 1: sticky; a pixel was lost.
- `drop_cnt`, out, 16: frames dropped; saturates at 0xFFFF.
- `fifo_level`, out, $clog2(FIFO_DEPTH)+1: current occupancy.
- `meas_width`, `meas_height`, out, 16: measured frame size (see Configuration).
- `meas_valid`, out, 1: measurement valid.

## Operation
- Input stage registers `vid_data`, `vid_de` and polarity-normalised vsync. Vsync edge = normalised vsync high now, low in previous cycle.
- FIFO entry is {tuser, tlast, data}, DATA_WIDTH+2 bits wide.
- FSM states:
  - WAIT_VSYNC: reset state; DE ignored.
  - ARMED: x=0, y=0.
  - ACTIVE: pixels are written.
  - DROP: pixels discarded.
- Transitions:
  - Vsync edge in any state → ARMED; counters cleared.
  - ARMED + DE → ACTIVE; this pixel is written with tuser=1.
  - ACTIVE after the last pixel of line HEIGHT-1 → WAIT_VSYNC. Extra DE before the next vsync is ignored.
  - Write attempt while FIFO is full and not read in the same cycle → DROP. Pixel lost, `overflow`←1, `drop_cnt`+1. Remains in DROP until the next vsync edge.
- Vsync edge in ACTIVE before the frame completes (short frame): `drop_cnt`+1, → ARMED. Beats already queued are still emitted; downstream resyncs on tuser.
- Counting:
  - x increments per written pixel. Gaps in DE mid-line are allowed and do not affect x.
  - tlast=1 when x==WIDTH-1, then x←0 and y+1.
- FIFO is first-word-fall-through. A read happens on `tvalid && tready`. Write and read in the same cycle while full is legal; level is unchanged.
- `tvalid` = FIFO not empty. `tdata`/`tlast`/`tuser` are forced to 0 while `tvalid`=0.
- `ovf_clr` and a new overflow in the same cycle: set wins.

## Timing
- Reset values:
  - `m_axis_tvalid`/`tdata`/`tlast`/`tuser`: 0.
  - `overflow`: 0; `drop_cnt`: 0; `fifo_level`: 0.
  - `meas_*`: 0.
  - FSM: WAIT_VSYNC.
- Reset mid-frame empties the FIFO immediately. The block waits for a fresh vsync edge.
- Latency: DE sampled at edge N → written at edge N+1 → `tvalid` high after edge N+2 (FIFO previously empty).
- `fifo_level` updates one cycle after the write/read edge.
- AXI rule: once `tvalid` is high, the beat holds stable until accepted. No combinational path from `tready` to `tvalid`.
- Sustained throughput is 1 pixel/clk when `tready`=1.

## Configuration
- `VID_IN_MEASURE_EN` defined:
  - `meas_width` = DE count of the first line of each frame.
  - `meas_height` = lines seen between vsync edges; a line ends on a DE falling edge.
  - Both latched at each vsync edge; `meas_valid`←1 after the first complete frame.
- Undefined: `meas_*` tied to 0 and no counters are synthesised. Port list is identical in both cases.

## Structure
- Shared package `bdc_pkg`:
  - FSM state enum.
  - FIFO entry field offsets (TUSER_BIT, TLAST_BIT).
  - DROP_CNT_W=16.
  - Shared `DATA_WIDTH`/`WIDTH`/`HEIGHT` defaults with the correction stage.
- One sub-module, `axis_sync_fifo`: parameterised width and depth, FWFT, exposes full/empty/level.

## Test plan
- WIDTH=8, HEIGHT=4; one vsync then 32 DE pixels, `tready`=1 → 32 beats; tuser on beat 0 only; tlast on beats 7, 15, 23, 31. First `tvalid` 2 cycles after first DE.
- DE gaps of 3 cycles every 2 pixels → identical beat sequence and tlast positions as contiguous input.
- FIFO_DEPTH=4, `tready`=0, 6 pixels → 4 queued; `overflow`=1; `drop_cnt`=1; remainder of frame absent. Next vsync and frame with `tready`=1 → full frame with tuser.
- Vsync edge after 2 of 4 lines → `drop_cnt`+1; next beat after the queued 16 carries tuser=1.
- Random `tready` over 3 frames → data order is preserved and tdata is stable while stalled. `rst_n` pulse mid-frame → all outputs 0, nothing emitted until the next vsync.
- `VID_IN_MEASURE_EN`, frame of 8×4 → `meas_width`=8, `meas_height`=4, `meas_valid`=1 after the second vsync.
